// File: rtl/pru_cmd_dispatcher.sv
// pru_cmd_dispatcher: memory-mapped draw-command FIFO that issues commands over the PRU start/busy/done handshake.
// Define PRU_CMD_TIMEOUT_EN to add a 16-bit WAIT_DONE watchdog with a sticky timeout status bit.
module pru_cmd_dispatcher #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        pru_start,
    output logic [1:0]  pru_shape_select,
    output logic [1:0]  pru_color,
    output logic [9:0]  pru_col,
    output logic [8:0]  pru_row,
    output logic [9:0]  pru_width,
    output logic [8:0]  pru_height_radius,
    output logic        pru_subtract,
    input  logic        pru_busy,
    input  logic        pru_done
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned GEOM_W = 19;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_RELEASE} state_t;

    typedef struct packed {
        logic [9:0] col;
        logic [8:0] row;
        logic [9:0] width;
        logic [8:0] height_radius;
        logic [1:0] shape;
        logic [1:0] color;
        logic       subtract;
    } cmd_t;

    state_t             state_q, state_d;
    logic               start_q, start_d;
    cmd_t               op_q, op_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [GEOM_W-1:0]  geom0_q, geom0_d, geom1_q, geom1_d;
    logic               ovf_q, ovf_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    cmd_t               fifo_q [DEPTH];
`ifdef PRU_CMD_TIMEOUT_EN
    logic               tmo_q, tmo_d;
    logic [15:0]        wd_q, wd_d;
`endif

    logic sel_geom0, sel_geom1, sel_push, sel_status;
    logic empty, full, idle, pop, push_req, push_ok, timeout_flag;
    logic [31:0] status_val, rd_val;
    cmd_t push_entry;
    logic unused_wdata;

    assign sel_geom0  = (bus_addr == BASE_ADDR);
    assign sel_geom1  = (bus_addr == BASE_ADDR + 32'd4);
    assign sel_push   = (bus_addr == BASE_ADDR + 32'd8);
    assign sel_status = (bus_addr == BASE_ADDR + 32'd12);

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign idle     = (state_q == S_IDLE) && empty;
    assign pop      = (state_q == S_IDLE) && !empty;
    assign push_req = bus_we && sel_push;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);

`ifdef PRU_CMD_TIMEOUT_EN
    assign timeout_flag = tmo_q;
`else
    assign timeout_flag = 1'b0;
`endif

    assign status_val = {16'h0, 8'(count_q), 3'b000, timeout_flag, ovf_q, idle, full, empty};
    assign push_entry = '{col: geom0_q[9:0], row: geom0_q[18:10],
                          width: geom1_q[9:0], height_radius: geom1_q[18:10],
                          shape: bus_wdata[1:0], color: bus_wdata[3:2], subtract: bus_wdata[4]};
    assign unused_wdata = ^bus_wdata[31:19];

    always_comb begin
        rd_val = '0;
        if (sel_geom0)       rd_val = {13'h0, geom0_q};
        else if (sel_geom1)  rd_val = {13'h0, geom1_q};
        else if (sel_status) rd_val = status_val;
    end

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        op_d     = op_q;
        rdata_d  = rdata_q;
        geom0_d  = geom0_q;
        geom1_d  = geom1_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
`ifdef PRU_CMD_TIMEOUT_EN
        tmo_d    = tmo_q;
        wd_d     = wd_q;
`endif

        if (bus_re) rdata_d = rd_val;

        if (bus_we && sel_geom0) geom0_d = bus_wdata[18:0];
        if (bus_we && sel_geom1) geom1_d = bus_wdata[18:0];
        if (bus_we && sel_status) begin
            ovf_d = 1'b0;
`ifdef PRU_CMD_TIMEOUT_EN
            tmo_d = 1'b0;
`endif
        end
        if (push_req && !push_ok) ovf_d = 1'b1;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    op_d     = fifo_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    start_d  = 1'b1;
                    state_d  = S_WAIT_DONE;
`ifdef PRU_CMD_TIMEOUT_EN
                    wd_d     = '0;
`endif
                end
            end
            S_WAIT_DONE: begin
                if (pru_done) begin
                    start_d = 1'b0;
                    state_d = S_RELEASE;
                end
`ifdef PRU_CMD_TIMEOUT_EN
                else if (wd_q == 16'hFFFF) begin
                    start_d = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
`endif
            end
            S_RELEASE: begin
                if (!pru_done && !pru_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            op_q     <= '0;
            rdata_q  <= '0;
            geom0_q  <= '0;
            geom1_q  <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef PRU_CMD_TIMEOUT_EN
            tmo_q    <= 1'b0;
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            op_q     <= op_d;
            rdata_q  <= rdata_d;
            geom0_q  <= geom0_d;
            geom1_q  <= geom1_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef PRU_CMD_TIMEOUT_EN
            tmo_q    <= tmo_d;
            wd_q     <= wd_d;
`endif
        end
    end

    // Queue storage needs no reset; count/pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= push_entry;
    end

    assign bus_rdata         = rdata_q;
    assign pru_start         = start_q;
    assign pru_shape_select  = op_q.shape;
    assign pru_color         = op_q.color;
    assign pru_col           = op_q.col;
    assign pru_row           = op_q.row;
    assign pru_width         = op_q.width;
    assign pru_height_radius = op_q.height_radius;
    assign pru_subtract      = op_q.subtract;

endmodule

// File: tb/tb_pru_cmd_dispatcher.sv
// Bench for pru_cmd_dispatcher: directed bus and PRU stimulus, a queue-level reference model
// compared every cycle, plus hand-computed expectations for the key scenarios.
module tb_pru_cmd_dispatcher;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] A_GEOM0  = 32'h4000_0100;
    localparam logic [31:0] A_GEOM1  = 32'h4000_0104;
    localparam logic [31:0] A_PUSH   = 32'h4000_0108;
    localparam logic [31:0] A_STATUS = 32'h4000_010C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bus_addr = '0, bus_wdata = '0;
    logic        bus_we = 1'b0, bus_re = 1'b0;
    logic [31:0] bus_rdata;
    logic        pru_start, pru_subtract;
    logic [1:0]  pru_shape_select, pru_color;
    logic [9:0]  pru_col, pru_width;
    logic [8:0]  pru_row, pru_height_radius;
    logic        pru_busy = 1'b0, pru_done = 1'b0;

    pru_cmd_dispatcher #(.DEPTH(DEPTH), .BASE_ADDR(32'h4000_0100)) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata),
        .pru_start(pru_start), .pru_shape_select(pru_shape_select), .pru_color(pru_color),
        .pru_col(pru_col), .pru_row(pru_row), .pru_width(pru_width),
        .pru_height_radius(pru_height_radius), .pru_subtract(pru_subtract),
        .pru_busy(pru_busy), .pru_done(pru_done)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [42:0] dut_ops;
    assign dut_ops = {pru_col, pru_row, pru_width, pru_height_radius,
                      pru_shape_select, pru_color, pru_subtract};

    // Reference model: command queue plus the three handshake phases, stepped once per clock.
    logic [42:0] m_q[$];
    int          m_phase = 0;
    logic        m_start = 1'b0;
    logic [42:0] m_ops = '0;
    logic [18:0] m_g0 = '0, m_g1 = '0;
    logic        m_ovf = 1'b0, m_tmo = 1'b0;
    logic [31:0] m_rdata = '0, m_rd;
    int          m_wd = 0;

    function automatic logic [31:0] m_status();
        logic [7:0] cnt;
        cnt = 8'(m_q.size());
        return {16'h0, cnt, 3'b000, m_tmo, m_ovf,
                (m_phase == 0 && m_q.size() == 0), (m_q.size() == DEPTH), (m_q.size() == 0)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_phase = 0; m_start = 1'b0; m_ops = '0; m_g0 = '0; m_g1 = '0;
            m_ovf = 1'b0; m_tmo = 1'b0; m_rdata = '0; m_wd = 0;
        end else begin
            m_rd = '0;
            if (bus_addr == A_GEOM0) m_rd = {13'h0, m_g0};
            if (bus_addr == A_GEOM1) m_rd = {13'h0, m_g1};
            if (bus_addr == A_STATUS) m_rd = m_status();
            if (bus_re) m_rdata = m_rd;
            if (bus_we && bus_addr == A_STATUS) begin m_ovf = 1'b0; m_tmo = 1'b0; end
            if (m_phase == 0 && m_q.size() > 0) begin
                m_ops = m_q.pop_front(); m_start = 1'b1; m_phase = 1; m_wd = 0;
            end else if (m_phase == 1) begin
                if (pru_done) begin m_start = 1'b0; m_phase = 2; end
`ifdef PRU_CMD_TIMEOUT_EN
                else if (m_wd == 65535) begin m_start = 1'b0; m_phase = 2; m_tmo = 1'b1; end
                else m_wd++;
`endif
            end else if (m_phase == 2) begin
                if (!pru_done && !pru_busy) m_phase = 0;
            end
            if (bus_we && bus_addr == A_PUSH) begin
                if (m_q.size() < DEPTH)
                    m_q.push_back({m_g0[9:0], m_g0[18:10], m_g1[9:0], m_g1[18:10],
                                   bus_wdata[1:0], bus_wdata[3:2], bus_wdata[4]});
                else
                    m_ovf = 1'b1;
            end
            if (bus_we && bus_addr == A_GEOM0) m_g0 = bus_wdata[18:0];
            if (bus_we && bus_addr == A_GEOM1) m_g1 = bus_wdata[18:0];
        end
    end

    // PRU stand-in: busy after start, done after pru_delay cycles, done held pru_hold cycles after start falls.
    int pru_delay = 20, pru_hold = 0, pru_st = 0, pru_cnt = 0;
    bit pru_never = 1'b0;
    initial forever begin
        @(posedge clk); #2;
        case (pru_st)
            0: if (pru_start) begin pru_busy = 1'b1; pru_cnt = 1; pru_st = 1; end
            1: begin
                if (!pru_start) begin pru_busy = 1'b0; pru_st = 0; end
                else if (!pru_never && pru_cnt >= pru_delay) begin
                    pru_busy = 1'b0; pru_done = 1'b1; pru_cnt = 0; pru_st = 2;
                end else pru_cnt++;
            end
            default: if (!pru_start) begin
                if (pru_cnt >= pru_hold) begin pru_done = 1'b0; pru_st = 0; end
                else pru_cnt++;
            end
        endcase
    end

    // Per-cycle compare against the model, plus start-edge bookkeeping.
    bit   chk_en = 1'b0;
    logic prev_start = 1'b0, prev_done = 1'b0, prev_busy = 1'b0;
    int   rises = 0;
    logic [1:0] rise_colors[$];
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_pru_start", 64'(pru_start), 64'(m_start));
            chk("cyc_operands", 64'(dut_ops), 64'(m_ops));
            chk("cyc_bus_rdata", 64'(bus_rdata), 64'(m_rdata));
            if (pru_start && !prev_start) begin
                rises++;
                rise_colors.push_back(pru_color);
                chk("start_after_release", 64'(prev_done | prev_busy), 64'd0);
            end
        end
        prev_start = pru_start; prev_done = pru_done; prev_busy = pru_busy;
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        @(negedge clk); bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); bus_addr = a; bus_re = 1'b1;
        @(negedge clk); bus_re = 1'b0; d = bus_rdata;
    endtask

    task automatic bus_rw(input logic [31:0] a, input logic [31:0] wd, output logic [31:0] d);
        @(negedge clk); bus_addr = a; bus_wdata = wd; bus_we = 1'b1; bus_re = 1'b1;
        @(negedge clk); bus_we = 1'b0; bus_re = 1'b0; d = bus_rdata;
    endtask

    task automatic wait_pru_quiet();
        int n;
        n = 0;
        while ((pru_done || pru_busy || pru_start) && n < 200) begin @(negedge clk); n++; end
        chk("pru_quiet_in_budget", 64'(n < 200), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    logic [31:0] st;
    int n;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        chk("reset_start", 64'(pru_start), 64'd0);
        chk("reset_operands", 64'(dut_ops), 64'd0);
        bus_read(A_STATUS, st);
        chk("reset_status", 64'(st), 64'h5);

        // Single rectangle command, 2-cycle issue latency, held operands
        bus_write(A_GEOM0, 32'h0000_1405);
        bus_write(A_GEOM1, 32'h0000_1C0A);
        bus_read(A_GEOM0, st);
        chk("geom0_readback", 64'(st), 64'h1405);
        bus_write(A_PUSH, 32'h4);
        chk("t1_start_not_yet", 64'(pru_start), 64'd0);
        @(negedge clk);
        chk("t1_start_rise", 64'(pru_start), 64'd1);
        chk("t1_col", 64'(pru_col), 64'd5);
        chk("t1_row", 64'(pru_row), 64'd5);
        chk("t1_width", 64'(pru_width), 64'd10);
        chk("t1_height", 64'(pru_height_radius), 64'd7);
        chk("t1_shape", 64'(pru_shape_select), 64'd0);
        chk("t1_color", 64'(pru_color), 64'd1);
        n = 0;
        while (!pru_done && n < 100) begin @(negedge clk); n++; end
        chk("t1_done_seen", 64'(pru_done), 64'd1);
        chk("t1_start_held", 64'(pru_start), 64'd1);
        chk("t1_ops_held", 64'(dut_ops), {21'h0, 10'd5, 9'd5, 10'd10, 9'd7, 2'd0, 2'd1, 1'b0});
        @(negedge clk);
        chk("t1_start_fall", 64'(pru_start), 64'd0);
        chk("t1_ops_after_fall", 64'(pru_col), 64'd5);
        wait_pru_quiet();

        // Fill the queue with the PRU stalled, then overflow and clear
        pru_never = 1'b1;
        repeat (DEPTH + 1) bus_write(A_PUSH, 32'h4);
        bus_read(A_STATUS, st);
        chk("t2_full_count8", 64'(st), 64'h0802);
        bus_write(A_PUSH, 32'h8);
        bus_read(A_STATUS, st);
        chk("t2_overflow_set", 64'(st), 64'h080A);
        bus_write(A_STATUS, 32'h0);
        bus_read(A_STATUS, st);
        chk("t2_overflow_clear", 64'(st), 64'h0802);

        // Push every cycle on a full queue while the PRU drains it: pushes coinciding with pops land
        pru_never = 1'b0; pru_delay = 2; pru_hold = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 30) pru_never = 1'b1;
            bus_addr = A_PUSH; bus_wdata = 32'(i << 2); bus_we = 1'b1;
        end
        @(negedge clk); bus_we = 1'b0;
        bus_read(A_STATUS, st);
        chk("t2_full_with_pop", 64'(st), 64'h080A);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_clears_start", 64'(pru_start), 64'd0);
        bus_read(A_STATUS, st);
        chk("rst_status", 64'(st), 64'h5);
        wait_pru_quiet();

        // Three commands in FIFO order with a slow-releasing PRU
        pru_never = 1'b0; pru_delay = 5; pru_hold = 3;
        rises = 0; rise_colors.delete();
        bus_write(A_GEOM0, (32'd20 << 10) | 32'd100);
        bus_write(A_GEOM1, (32'd30 << 10) | 32'd40);
        bus_write(A_PUSH, 32'h04);
        bus_write(A_PUSH, 32'h09);
        bus_write(A_PUSH, 32'h1E);
        bus_rw(A_GEOM0, 32'h0001_2345, st);
        chk("rw_returns_old", 64'(st), 64'h5064);
        bus_read(A_GEOM0, st);
        chk("rw_write_landed", 64'(st), 64'h12345);
        repeat (150) @(negedge clk);
        chk("t3_three_starts", 64'(rises), 64'd3);
        if (rise_colors.size() == 3) begin
            chk("t3_order0", 64'(rise_colors[0]), 64'd1);
            chk("t3_order1", 64'(rise_colors[1]), 64'd2);
            chk("t3_order2", 64'(rise_colors[2]), 64'd3);
        end else begin
            chk("t3_order_count", 64'(rise_colors.size()), 64'd3);
        end
        bus_read(A_STATUS, st);
        chk("t3_idle_status", 64'(st), 64'h5);

        // Reset during WAIT_DONE with four queued
        pru_never = 1'b1;
        repeat (5) bus_write(A_PUSH, 32'h4);
        bus_read(A_STATUS, st);
        chk("t4_count4", 64'(st), 64'h0400);
        chk("t4_start_high", 64'(pru_start), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_start_drop", 64'(pru_start), 64'd0);
        rst = 1'b0;
        rises = 0;
        bus_read(A_STATUS, st);
        chk("t4_status_after_rst", 64'(st), 64'h5);
        repeat (20) @(negedge clk);
        chk("t4_no_more_starts", 64'(rises), 64'd0);

        // PRU that never completes
        bus_write(A_PUSH, 32'h4);
        @(negedge clk);
        chk("t5_started", 64'(pru_start), 64'd1);
`ifdef PRU_CMD_TIMEOUT_EN
        n = 0;
        while (pru_start && n < 70000) begin @(negedge clk); n++; end
        chk("t5_start_dropped", 64'(pru_start), 64'd0);
        chk("t5_timeout_length", 64'(n >= 65530 && n <= 65540), 64'd1);
        bus_read(A_STATUS, st);
        chk("t5_timeout_bit", 64'(st[4]), 64'd1);
        bus_write(A_STATUS, 32'h0);
        bus_read(A_STATUS, st);
        chk("t5_timeout_clear", 64'(st[4]), 64'd0);
`else
        repeat (66000) @(negedge clk);
        chk("t5_still_waiting", 64'(pru_start), 64'd1);
        bus_read(A_STATUS, st);
        chk("t5_status_no_timeout", 64'(st), 64'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pru_cmd_dispatcher.md
# pru_cmd_dispatcher

- Bus-side initiator for the PRU draw engine.
- Accepts memory-mapped draw commands from the CPU and queues them in a small command FIFO.
- Issues each command to the PRU over its start/busy/done handshake, holding every operand stable for the whole transaction.
- Sits between the CPU load/store bus and the PRU control inputs, so software can post several shapes without polling `done`.

## Interface
Parameters:
- DEPTH, 8, command FIFO entries (power of two, 2..64)
- BASE_ADDR, 32'h40000100, byte address of register 0

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- bus_addr  in  32  byte address
- bus_wdata  in  32  write data
- bus_we  in  1  write strobe, one cycle per access
- bus_re  in  1  read strobe
- bus_rdata  out  32  read data, registered
- pru_start  out  1  start request to PRU
- pru_shape_select  out  2  00 rect, 01 circle, 1x bitmap
- pru_color  out  2  color index
- pru_col  out  10  column operand
- pru_row  out  9  row operand
- pru_width  out  10  rectangle width
- pru_height_radius  out  9  height or radius
- pru_subtract  out  1  subtract flag
- pru_busy  in  1  PRU busy
- pru_done  in  1  PRU done

## Operation
Register map (word offsets from BASE_ADDR):
- +0x0 GEOM0, write: col = wdata[9:0], row = wdata[18:10]; staged only.
- +0x4 GEOM1, write: width = wdata[9:0], height_radius = wdata[18:10]; staged only.
- +0x8 PUSH, write: shape = wdata[1:0], color = wdata[3:2], subtract = wdata[4].
  - Enqueues a 43-bit entry {GEOM0, GEOM1, PUSH fields}.
  - Staging registers keep their values, so repeated PUSH writes re-use the same geometry.
- +0xC STATUS:
  - Read fields: [0] empty, [1] full, [2] idle, [3] overflow (sticky), [4] timeout (sticky), [15:8] count, others 0.
  - Idle means FSM is in IDLE and the FIFO is empty.
  - Any write to STATUS clears both sticky bits.
- Reads of GEOM0/GEOM1 return the staged values in the same bit positions. Reads of PUSH or any unmapped address return 0.

FIFO:
- A PUSH is accepted when count < DEPTH, or when a pop occurs in the same cycle.
- A PUSH that is not accepted is dropped and sets overflow.
- Pointers wrap modulo DEPTH. count is stored with width log2(DEPTH)+1.

FSM:
- IDLE:
  - If the FIFO is not empty: pop the head into the output operand registers, set pru_start=1, go to WAIT_DONE.
- WAIT_DONE:
  - pru_start stays 1 and the operands stay stable.
  - When pru_done==1: set pru_start=0, go to RELEASE.
- RELEASE:
  - When pru_done==0 and pru_busy==0: go to IDLE.
  - Operands stay stable until the next pop.

## Timing
- Reset values:
  - pru_start = 0; all pru operand outputs = 0; bus_rdata = 0; state = IDLE.
  - FIFO is empty; staging registers = 0; sticky bits = 0.
- Bus read latency is 1 cycle: bus_rdata is valid on the cycle after bus_re and holds until the next read.
- A write becomes visible in STATUS on the cycle after bus_we.
- PUSH into an empty idle dispatcher: pru_start rises 2 cycles after the bus_we cycle (enqueue edge, then pop edge).
- pru_start falls 1 cycle after pru_done is sampled high.
- Back-to-back commands: the next pru_start rises no earlier than 1 cycle after the PRU has returned both done and busy low.
- A simultaneous PUSH and pop on a full FIFO is accepted; count is unchanged.
- When bus_we and bus_re occur in the same cycle, the write takes effect and the read returns the pre-write value.
- rst asserted mid-transaction:
  - pru_start drops on the next edge and the queue is discarded.
  - The PRU returns to IDLE because start is low.

## Configuration
- PRU_CMD_TIMEOUT_EN, when defined:
  - A 16-bit watchdog counts cycles in WAIT_DONE and resets on entry to the state.
  - At 65535 cycles without pru_done it sets pru_start=0, sets the sticky timeout bit, and goes to RELEASE.
- When undefined: there is no counter, WAIT_DONE waits indefinitely, and STATUS[4] reads 0.

## Test plan
- Reset, then read STATUS -> 0x00000005 (empty, idle).
- Write GEOM0=0x00001405 (col 5, row 5), GEOM1=0x00001C0A (width 10, height 7), PUSH=0x4 (rect, color 1); model PRU raises done 20 cycles after start -> pru_start high 2 cycles after the PUSH, operands 5/5/10/7/00/01 stable until done, start falls 1 cycle after done.
- Hold pru_done low, push DEPTH+1=9 commands -> STATUS count=8 (only the first has popped, so 8 remain queued). Once the queue holds 8, further pushes raise overflow=1 and are dropped. A STATUS write clears overflow to 0.
- Three pushes with different colors and a PRU that keeps done high for 3 cycles after start falls -> exactly three start pulses, in FIFO order, each starting only after done and busy are low.
- Assert rst while in WAIT_DONE with 4 commands queued -> next cycle pru_start=0, STATUS=0x05, no further starts.
- With PRU_CMD_TIMEOUT_EN, a PRU that never asserts done -> pru_start drops after 65535 cycles and STATUS[4]=1. Without the macro, start is still high at cycle 70000.
